scr1_tb_imem_resp: RTL and testbench
====================================

SCR1_TB_IMEM_RESP -- requirements
Module: scr1_tb_imem_resp

Interface
REQ-001 Parameters SHALL be: MEM_WORDS 1024, instruction storage depth in 32-bit words; PEND_DEPTH 2, maximum outstanding accepted requests; LATENCY 2, accept-to-response cycles (legal range 1..15).
REQ-002 Clock and reset SHALL be: clk input 1, sole clock; rst_n input 1, asynchronous active-low reset.
REQ-003 The following ports SHALL exist (name, direction, width, meaning):
- imem_req, input, 1: core request valid.
- imem_cmd, input, 1: 0 = read, 1 = write.
- imem_addr, input, 32: byte address.
- imem_req_ack, output, 1: request accepted this cycle.
- imem_rdata, output, 32: read data.
- imem_resp, output, 2: 00 IDLE, 01 OKAY, 10 ERROR.
- stall, input, 1: testbench backpressure; forces imem_req_ack low.
- ld_we, input, 1: backdoor storage write enable.
- ld_addr, input, 32: backdoor word index.
- ld_data, input, 32: backdoor write data.
- resp_cnt, output, 32: total responses issued.
- err_cnt, output, 32: total ERROR responses issued.

Function
REQ-004 imem_req_ack SHALL be combinational and equal to rst_n & ~stall & (pending count < PEND_DEPTH); a pop in the same cycle SHALL NOT free a slot for that cycle.
REQ-005 A request SHALL be accepted only in a cycle where imem_req and imem_req_ack are both 1; on acceptance imem_addr, the error flag and a countdown loaded with LATENCY SHALL be pushed into the pending queue.
REQ-006 The error flag SHALL be set when imem_cmd = 1, or imem_addr[1:0] != 0, or imem_addr[31:2] >= MEM_WORDS.
REQ-007 Every pending entry's countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-008 A request accepted at cycle T into an empty queue SHALL have its response driven on the registered outputs at cycle T+LATENCY.
REQ-009 Responses SHALL be issued in acceptance order, at most one per cycle.
REQ-010 The head entry SHALL be popped in the cycle its countdown is 0, with the response appearing on the registered outputs in the following cycle.
REQ-011 An OKAY response SHALL drive imem_resp = 01 and imem_rdata = storage[addr[31:2]] as read at pop time.
REQ-012 An ERROR response SHALL drive imem_resp = 10 and imem_rdata = 0.
REQ-013 In every cycle without a response, imem_resp SHALL be 00 and imem_rdata SHALL be 0; each response SHALL last exactly one cycle.
REQ-014 A backdoor write SHALL update storage on the clock edge when ld_we = 1 and ld_addr < MEM_WORDS; ld_addr >= MEM_WORDS SHALL be ignored.
REQ-015 When a backdoor write and a pop target the same word in the same cycle, the pop SHALL return the old data.
REQ-016 Simultaneous push and pop SHALL leave the pending count unchanged; pointers SHALL wrap modulo PEND_DEPTH.
REQ-017 resp_cnt SHALL increment on every response and err_cnt on every ERROR response; both SHALL wrap at 2^32.
REQ-018 Pending-state encoding SHALL be: EMPTY (count 0), PARTIAL, FULL (count = PEND_DEPTH); imem_req_ack SHALL be 0 in FULL.

Reset
REQ-019 While rst_n = 0: queue EMPTY, pointers 0, imem_resp = 00, imem_rdata = 0, imem_req_ack = 0, resp_cnt = 0, err_cnt = 0.
REQ-020 Reset asserted mid-operation SHALL discard all pending entries without issuing their responses.
REQ-021 Storage contents SHALL NOT be affected by reset.

Structure
REQ-022 Package scr1_tb_imem_pkg SHALL hold: the response-code enum (IDLE/OKAY/ERROR), the command enum (RD/WR), the pending-entry struct (addr, err, countdown) and the pending-state enum.
REQ-023 The pending queue SHALL be a sub-module, scr1_tb_imem_pend_fifo, owning storage, pointers, count and per-entry countdowns.

Verification
REQ-024 The bench SHALL cover:
- Basic read (LATENCY=2): storage[4] = 0x00C5F533; read 0x10 accepted at T -> imem_resp = 01 and rdata = 0x00C5F533 at T+2 only.
- Back-to-back reads: reads 0x0, 0x4 accepted in consecutive cycles with LATENCY=2 -> responses at T+2 and T+3 in order; third request not acked while FULL.
- Errors: misaligned 0x2, write to 0x8, and address 0x1000 with MEM_WORDS=1024 -> three responses of 10, rdata = 0, err_cnt = 3.
- Backpressure: stall=1 with imem_req=1 for 5 cycles -> imem_req_ack = 0 and no responses; stall released -> accept next cycle.
- Reset mid-flight: two pending entries, rst_n low for 1 cycle -> no responses emitted, resp_cnt = 0, storage preserved on a subsequent read.
- Collision: ld_we on word 3 in the same cycle as pop of 0xC -> old data returned, new data on the next read.

Source files
------------

// File: rtl/scr1_tb_imem_pkg.sv
// Shared types for the testbench instruction-memory responder: response and
// command codes, the pending-request entry and the pending-queue occupancy.
package scr1_tb_imem_pkg;

  // Width of the per-entry countdown; it covers LATENCY values 1..15.
  localparam int unsigned CD_W = 4;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'b00,
    RESP_OKAY  = 2'b01,
    RESP_ERROR = 2'b10
  } imem_resp_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } imem_cmd_e;

  typedef struct packed {
    logic [31:0]     addr;
    logic            err;
    logic [CD_W-1:0] countdown;
  } pend_entry_t;

  typedef enum logic [1:0] {
    PEND_EMPTY   = 2'b00,
    PEND_PARTIAL = 2'b01,
    PEND_FULL    = 2'b10
  } pend_state_e;

  // Map an occupancy count onto the coarse queue state.
  function automatic pend_state_e pend_state_of(input int unsigned cnt,
                                                input int unsigned depth);
    if (cnt == 0)          return PEND_EMPTY;
    else if (cnt >= depth) return PEND_FULL;
    else                   return PEND_PARTIAL;
  endfunction

  // Countdown step that holds at zero once the entry is due.
  function automatic logic [CD_W-1:0] cd_dec(input logic [CD_W-1:0] cd);
    return (cd == '0) ? '0 : cd - 1'b1;
  endfunction

endpackage

// File: rtl/scr1_tb_imem_pend_fifo.sv
// In-order queue of accepted instruction fetches. Each entry carries its own
// countdown; the head leaves the queue in the cycle its countdown reads zero.
module scr1_tb_imem_pend_fifo
  import scr1_tb_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  pend_entry_t push_entry,
  output logic        pop,
  output pend_entry_t head,
  output pend_state_e state
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  pend_entry_t      entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head    = entries[rd_ptr];
  assign pop     = (state != PEND_EMPTY) && (head.countdown == '0);
  // A full queue refuses pushes even if the head leaves this cycle.
  assign do_push = push && (state != PEND_FULL);

  // Next occupancy: a push and a pop together cancel out.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the unlisted
    // case arms from inferring a latch.
    count_next = count;
    case ({do_push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and the registered occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= PEND_EMPTY;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
      state <= pend_state_of(32'(count_next), DEPTH);
    end
  end

  // Entry payload: load on push, otherwise tick every countdown toward zero.
  always_ff @(posedge clk) begin
    // NOTE: entry storage has no reset; validity comes only from the
    // pointers and count, which are reset, so stale payload is never used.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_ptr == PTR_W'(i))) begin
        entries[i] <= push_entry;
      end else begin
        entries[i].countdown <= cd_dec(entries[i].countdown);
      end
    end
  end

endmodule

// File: rtl/scr1_tb_imem_resp.sv
// Testbench-side instruction memory for the SCR1 fetch port: accepts reads
// into a small pending queue, answers them after a fixed latency from a
// backdoor-loadable word store, and flags bad requests with ERROR.
module scr1_tb_imem_resp
  import scr1_tb_imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned PEND_DEPTH = 2,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic        imem_cmd,
  input  logic [31:0] imem_addr,
  output logic        imem_req_ack,
  output logic [31:0] imem_rdata,
  output logic [1:0]  imem_resp,
  input  logic        stall,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] resp_cnt,
  output logic [31:0] err_cnt
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]   mem [MEM_WORDS];

  logic          accept;
  logic          req_err;
  pend_entry_t   push_entry;
  logic          pop;
  pend_entry_t   head;
  pend_state_e   pend_state;
  logic [AW-1:0] head_idx;
  logic          addr_unused;

  imem_resp_e    resp_q;
  logic [31:0]   rdata_q;
  logic [31:0]   resp_cnt_q;
  logic [31:0]   err_cnt_q;

  // Handshake: no acceptance in reset, under stall, or with the queue full.
  assign imem_req_ack = rst_n & ~stall & (pend_state != PEND_FULL);
  assign accept       = imem_req & imem_req_ack;

  // Writes, misaligned fetches and out-of-range words all answer ERROR.
  assign req_err = (imem_cmd == CMD_WR)
                 | (imem_addr[1:0] != 2'b00)
                 | (imem_addr[31:2] >= 30'(MEM_WORDS));

  // The accept cycle counts as the first countdown step, so the entry lands
  // holding LATENCY-1 and pops exactly LATENCY edges after acceptance.
  assign push_entry = '{
    addr:      imem_addr,
    err:       req_err,
    countdown: CD_W'(LATENCY - 1)
  };

  scr1_tb_imem_pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .state      (pend_state)
  );

  // Only error-free entries index the store, so the low word bits suffice.
  assign head_idx    = head.addr[AW+1:2];
  assign addr_unused = ^{head.addr[31:AW+2], head.addr[1:0]};

  // Backdoor loader; out-of-range word indices are dropped.
  always_ff @(posedge clk) begin
    if (ld_we && (ld_addr < 32'(MEM_WORDS))) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  // Response stage: one-cycle response per pop, idle and zero otherwise.
  // Reading the store here returns pre-edge data when a backdoor write hits
  // the same word on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q     <= RESP_IDLE;
      rdata_q    <= '0;
      resp_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      resp_q  <= RESP_IDLE;
      rdata_q <= '0;
      if (pop) begin
        resp_cnt_q <= resp_cnt_q + 32'd1;
        if (head.err) begin
          resp_q    <= RESP_ERROR;
          err_cnt_q <= err_cnt_q + 32'd1;
        end else begin
          resp_q  <= RESP_OKAY;
          rdata_q <= mem[head_idx];
        end
      end
    end
  end

  assign imem_resp  = resp_q;
  assign imem_rdata = rdata_q;
  assign resp_cnt   = resp_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_scr1_tb_imem_resp.sv
// Directed bench for scr1_tb_imem_resp with default parameters
// (MEM_WORDS=1024, PEND_DEPTH=2, LATENCY=2). Inputs change 1 time unit after
// a rising edge; outputs are sampled on the falling edge.
module tb_scr1_tb_imem_resp;

  localparam logic [31:0] W0 = 32'h0000_0113;
  localparam logic [31:0] W1 = 32'h0040_0093;
  localparam logic [31:0] W2 = 32'hDEAD_BEEF;
  localparam logic [31:0] W4 = 32'h00C5_F533;
  localparam logic [31:0] OLD3 = 32'h1234_5678;
  localparam logic [31:0] NEW3 = 32'hCAFE_F00D;
  localparam logic [31:0] BAD3 = 32'h5555_AAAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        stall;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] resp_cnt;
  logic [31:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  scr1_tb_imem_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_req_ack (imem_req_ack),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .resp_cnt     (resp_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Stimulus helper: one backdoor write, starting and ending at edge+1.
  task automatic backdoor(input logic [31:0] idx, input logic [31:0] data);
    ld_we = 1'b1; ld_addr = idx; ld_data = data;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // Stimulus helper: hold a request until accepted; returns 1 unit after the
  // accepting edge with imem_req dropped. A timeout counts as a miscompare.
  task automatic issue(input logic cmd, input logic [31:0] addr);
    int guard = 0;
    imem_req = 1'b1; imem_cmd = cmd; imem_addr = addr;
    @(negedge clk);
    while (imem_req_ack !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (imem_req_ack !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: addr %h never acked", addr);
    end
    @(posedge clk); #1;
    imem_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", imem_req_ack); end
    n_vec++; if (imem_resp !== 2'b00) begin n_err++; $display("FAIL reset_resp: got %b want 00", imem_resp); end
    n_vec++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", imem_rdata); end
    n_vec++; if (resp_cnt !== 32'h0) begin n_err++; $display("FAIL reset_resp_cnt: got %0d want 0", resp_cnt); end
    n_vec++; if (err_cnt !== 32'h0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    backdoor(32'd4, W4);
    imem_req = 1'b1; imem_cmd = 1'b0; imem_addr = 32'h10;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL basic_ack: got %b want 1", imem_req_ack); end
    @(posedge clk); #1;               // accepting edge T
    imem_req = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      exp_resp = (k == 2) ? 2'b01 : 2'b00;
      exp_data = (k == 2) ? W4 : 32'h0;
      n_vec++; if (imem_resp !== exp_resp) begin n_err++; $display("FAIL basic_resp T+%0d: got %b want %b", k, imem_resp, exp_resp); end
      n_vec++; if (imem_rdata !== exp_data) begin n_err++; $display("FAIL basic_rdata T+%0d: got %h want %h", k, imem_rdata, exp_data); end
    end
    n_vec++; if (resp_cnt !== 32'd1) begin n_err++; $display("FAIL basic_resp_cnt: got %0d want 1", resp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    backdoor(32'd0, W0);
    backdoor(32'd1, W1);
    backdoor(32'd2, W2);
    imem_req = 1'b1; imem_cmd = 1'b0; imem_addr = 32'h0;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack0: got %b want 1", imem_req_ack); end
    @(posedge clk); #1;               // edge T: 0x0 accepted
    imem_addr = 32'h4;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack1: got %b want 1", imem_req_ack); end
    @(posedge clk); #1;               // edge T+1: 0x4 accepted, queue full
    imem_addr = 32'h8;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b0) begin n_err++; $display("FAIL b2b_full_ack: got %b want 0", imem_req_ack); end
    n_vec++; if (imem_resp !== 2'b00) begin n_err++; $display("FAIL b2b_resp_T1: got %b want 00", imem_resp); end
    @(posedge clk);                   // edge T+2: first pop, no push
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL b2b_resp_T2: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== W0) begin n_err++; $display("FAIL b2b_rdata_T2: got %h want %h", imem_rdata, W0); end
    n_vec++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack_after_pop: got %b want 1", imem_req_ack); end
    @(posedge clk); #1;               // edge T+3: second pop, 0x8 accepted
    imem_req = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL b2b_resp_T3: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== W1) begin n_err++; $display("FAIL b2b_rdata_T3: got %h want %h", imem_rdata, W1); end
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b00) begin n_err++; $display("FAIL b2b_resp_T4: got %b want 00", imem_resp); end
    @(posedge clk);                   // edge T+5: third response
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL b2b_resp_T5: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== W2) begin n_err++; $display("FAIL b2b_rdata_T5: got %h want %h", imem_rdata, W2); end
    n_vec++; if (resp_cnt !== 32'd4) begin n_err++; $display("FAIL b2b_resp_cnt: got %0d want 4", resp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h0000_0002, 32'h0000_0008, 32'h0000_1000};
    logic        cmds  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(cmds[i], addrs[i]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++; if (imem_resp !== 2'b10) begin n_err++; $display("FAIL err_resp[%0d] addr %h: got %b want 10", i, addrs[i], imem_resp); end
      n_vec++; if (imem_rdata !== 32'h0) begin n_err++; $display("FAIL err_rdata[%0d] addr %h: got %h want 0", i, addrs[i], imem_rdata); end
      @(posedge clk); #1;
    end
    n_vec++; if (err_cnt !== 32'd3) begin n_err++; $display("FAIL err_cnt: got %0d want 3", err_cnt); end
    n_vec++; if (resp_cnt !== 32'd7) begin n_err++; $display("FAIL err_resp_cnt: got %0d want 7", resp_cnt); end
  endtask

  task automatic test_backpressure();
    stall = 1'b1;
    imem_req = 1'b1; imem_cmd = 1'b0; imem_addr = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (imem_req_ack !== 1'b0) begin n_err++; $display("FAIL stall_ack[%0d]: got %b want 0", i, imem_req_ack); end
      n_vec++; if (imem_resp !== 2'b00) begin n_err++; $display("FAIL stall_resp[%0d]: got %b want 00", i, imem_resp); end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b1) begin n_err++; $display("FAIL unstall_ack: got %b want 1", imem_req_ack); end
    @(posedge clk); #1;
    imem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL unstall_resp: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== W1) begin n_err++; $display("FAIL unstall_rdata: got %h want %h", imem_rdata, W1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    issue(1'b0, 32'h0);
    issue(1'b0, 32'h4);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_req_ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack: got %b want 0", imem_req_ack); end
    n_vec++; if (resp_cnt !== 32'h0) begin n_err++; $display("FAIL midrst_resp_cnt: got %0d want 0", resp_cnt); end
    n_vec++; if (err_cnt !== 32'h0) begin n_err++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (imem_resp !== 2'b00) begin n_err++; $display("FAIL midrst_resp[%0d]: got %b want 00", i, imem_resp); end
      @(posedge clk); #1;
    end
    n_vec++; if (resp_cnt !== 32'h0) begin n_err++; $display("FAIL midrst_resp_cnt_after: got %0d want 0", resp_cnt); end
    issue(1'b0, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL midrst_read_resp: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== W1) begin n_err++; $display("FAIL midrst_read_rdata: got %h want %h", imem_rdata, W1); end
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    backdoor(32'd3, OLD3);
    issue(1'b0, 32'hC);               // accepted at edge T
    @(posedge clk); #1;               // after edge T+1
    ld_we = 1'b1; ld_addr = 32'd3; ld_data = NEW3;
    @(posedge clk); #1;               // edge T+2: pop and write together
    ld_we = 1'b0;
    @(negedge clk);
    n_vec++; if (imem_resp !== 2'b01) begin n_err++; $display("FAIL coll_resp: got %b want 01", imem_resp); end
    n_vec++; if (imem_rdata !== OLD3) begin n_err++; $display("FAIL coll_rdata_old: got %h want %h", imem_rdata, OLD3); end
    @(posedge clk); #1;
    backdoor(32'd1027, BAD3);         // out of range, must be dropped
    issue(1'b0, 32'hC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (imem_rdata !== NEW3) begin n_err++; $display("FAIL coll_rdata_new: got %h want %h", imem_rdata, NEW3); end
    n_vec++; if (resp_cnt !== 32'd3) begin n_err++; $display("FAIL coll_resp_cnt: got %0d want 3", resp_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req = 1'b0; imem_cmd = 1'b0; imem_addr = 32'h0;
    stall = 1'b0;
    ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
